blackjack_table: RTL
====================

# blackjack_table

Multi-player blackjack round controller. It scores up to NUM_PLAYERS hands against an automatic dealer, with soft-ace valuation, natural-blackjack detection and automatic bust hand-off. The dealer hits by itself until it reaches DEALER_STAND. The block sits between the card-source/button front end and the per-player result LEDs, and holds each round's outcome until the next START_I.

## Interface
- NUM_PLAYERS, 2: number of player hands, 1..8.
- SCORE_W, 5: hard-total width; must hold TARGET+10.
- TARGET, 21: bust threshold; a total above TARGET is a bust.
- DEALER_STAND, 17: dealer stops once its best total is at or above this value.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START_I  in  1  begin a new round; accepted in IDLE or DONE.
- HIT_I  in  1  active player takes CARD_I this cycle.
- STAY_I  in  1  active player ends turn.
- CARD_VALID_I  in  1  CARD_I valid for the dealer while DEALER_REQ_O=1.
- CARD_I  in  4  card code.
- ACTIVE_PLAYER_O  out  $clog2(NUM_PLAYERS) (min 1)  index of the player whose turn it is.
- DEALER_REQ_O  out  1  dealer needs a card.
- DONE_O  out  1  outcomes valid.
- WIN_O / TIE_O / LOSE_O  out  NUM_PLAYERS each  per-player outcome, one-hot per player when DONE_O=1.

## Operation
- Card decode:
  - 1 = ace, counted as 1 in the hard total.
  - 2..10 = face value.
  - 11..13 = 10.
  - 0, 14 and 15 are ignored; no state change and no card counted.
- Per hand, the block keeps:
  - hard total, saturating at 2^SCORE_W-1;
  - has_ace flag;
  - card count, saturating at 3.
- Derived per-hand values:
  - best = hard+10 if has_ace and hard+10 ≤ TARGET; otherwise best = hard.
  - bust = hard > TARGET.
  - natural = (count==2 && best==TARGET).
- FSM states: IDLE, PLAYER, DEALER, RESULT, DONE.
- IDLE, or DONE, with START_I=1: clear all hands and outcome vectors, set active player p=0, go to PLAYER.
- PLAYER, card handling: HIT_I=1 adds CARD_I to hand p.
- PLAYER, end of turn: the turn ends on STAY_I=1, or in the cycle after hand p becomes bust.
  - If HIT_I and STAY_I are both 1 in the same cycle, the card is added and then the turn ends.
  - At end of turn, p increments; after the last player, the FSM goes to DEALER.
- DEALER:
  - DEALER_REQ_O = (dealer best < DEALER_STAND).
  - While DEALER_REQ_O=1, CARD_VALID_I=1 adds CARD_I to the dealer hand.
  - CARD_VALID_I is ignored when DEALER_REQ_O=0, and in every other state.
  - When DEALER_REQ_O=0, the FSM goes to RESULT.
  - HIT_I and STAY_I are ignored in DEALER.
- RESULT, per player, evaluated in priority order:
  1. Player bust: LOSE, even if the dealer is also bust.
  2. Dealer bust: WIN.
  3. Exactly one of the two hands is natural: the natural wins.
  4. Otherwise compare best totals: higher wins; equal gives TIE.
- RESULT registers the outcomes and goes to DONE.
- DONE: holds outcomes and DONE_O=1 until START_I.
- START_I is ignored in PLAYER, DEALER and RESULT.

## Timing
- All inputs are sampled at the rising edge of CLK.
- Reset values (RST=1 at the edge): state IDLE, all hands 0, ACTIVE_PLAYER_O=0, DEALER_REQ_O=0, DONE_O=0, WIN/TIE/LOSE all 0.
- Reset mid-round aborts the round completely; no outcome is produced.
- START_I at edge n: PLAYER state and cleared hands are visible after edge n. Outputs are registered, so DONE_O drops to 0 in that same cycle.
- Bust card taken at edge n: ACTIVE_PLAYER_O advances at edge n+1.
- STAY_I at edge n: ACTIVE_PLAYER_O advances at edge n.
- Dealer:
  - DEALER_REQ_O is registered. It reflects the dealer hand one cycle after each card.
  - The dealer card that reaches the stand value is taken at edge n; the FSM enters RESULT at n+1, and DONE_O plus the outcomes appear at n+2.
  - If the dealer needs no card on entry (not possible from a cleared hand, but covered), DEALER lasts one cycle.
- Arithmetic:
  - Unsigned.
  - The best-total adder is SCORE_W+1 bits wide, so it does not overflow.

## Structure
- Package blackjack_pkg:
  - state enum;
  - CARD_ACE and FACE_VALUE constants;
  - function card_value(CARD_I) returning 0..10, where 0 means invalid.
- Sub-module blackjack_hand:
  - contents: one hand accumulator with clear, add and card inputs;
  - outputs: hard, best, bust and natural;
  - instantiated NUM_PLAYERS+1 times, once per player plus one for the dealer.
- The top level holds the FSM, the player index, dealer request logic and the outcome registers.

## Test plan
- 2 players:
  - P0 takes 10, 7 then stays; P1 takes ace, 9 then stays.
  - Dealer receives 10, 8.
  - Required: P0 LOSE (17<18), P1 WIN (soft 20), DONE_O 2 cycles after the dealer's 8.
- P0 takes 10, 6, 9 (bust 25): ACTIVE_PLAYER_O advances without STAY_I. Dealer receives 10, 6, 8 (bust 24). Required: P0 LOSE.
- Natural:
  - P0 takes ace, 13.
  - Dealer receives 7, 4, 10 (21, three cards).
  - Required: P0 WIN; DEALER_REQ_O drops after the dealer's 10.
- Soft-ace and tie:
  - P0 takes ace, 6, 10 (hard 17) then stays.
  - Dealer receives 10, 7.
  - Required: TIE.
- Robustness:
  - Card codes 0 and 15, and CARD_VALID_I during PLAYER, leave totals unchanged.
  - HIT_I with STAY_I in the same cycle adds the card then advances.
- RST asserted during DEALER: all outputs 0 and IDLE after the edge. A following START_I starts a clean round.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared types and card decoding for the blackjack round controller.
package blackjack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAYER,
    ST_DEALER,
    ST_RESULT,
    ST_DONE
  } state_t;

  localparam logic [3:0] CARD_ACE   = 4'd1;
  localparam logic [3:0] FACE_VALUE = 4'd10;

  // Returns the hard value of a card code; 0 marks a code that is not a card.
  function automatic logic [3:0] card_value(input logic [3:0] card);
    if (card == 4'd0) return 4'd0;
    if (card <= FACE_VALUE) return card;
    if (card <= 4'd13) return FACE_VALUE;
    return 4'd0;
  endfunction

endpackage

// File: rtl/blackjack_hand.sv
// One blackjack hand: saturating hard total, ace flag and card count,
// with soft-ace best total, bust and natural derived from them.
module blackjack_hand
  import blackjack_pkg::*;
#(
  parameter int SCORE_W = 5,
  parameter int TARGET  = 21
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear,
  input  logic               add,
  input  logic [3:0]         card,
  output logic [SCORE_W-1:0] hard,
  output logic [SCORE_W-1:0] best,
  output logic               bust,
  output logic               natural
);

  logic [SCORE_W-1:0] hard_reg;
  logic               has_ace_reg;
  logic [1:0]         count_reg;
  logic [3:0]         card_val;
  logic [SCORE_W:0]   hard_sum;
  logic [SCORE_W:0]   soft_sum;

  assign card_val = card_value(card);
  assign hard_sum = {1'b0, hard_reg} + (SCORE_W+1)'(card_val);
  assign soft_sum = {1'b0, hard_reg} + (SCORE_W+1)'(FACE_VALUE);

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      hard_reg    <= '0;
      has_ace_reg <= 1'b0;
      count_reg   <= 2'd0;
    end else if (add && card_val != 4'd0) begin
      hard_reg <= hard_sum[SCORE_W] ? '1 : hard_sum[SCORE_W-1:0];
      if (card == CARD_ACE) has_ace_reg <= 1'b1;
      if (count_reg != 2'd3) count_reg <= count_reg + 2'd1;
    end
  end

  // One ace may count as 11 only while that keeps the hand at or under TARGET.
  assign hard    = hard_reg;
  assign best    = (has_ace_reg && soft_sum <= (SCORE_W+1)'(TARGET)) ? soft_sum[SCORE_W-1:0] : hard_reg;
  assign bust    = hard_reg > SCORE_W'(TARGET);
  assign natural = (count_reg == 2'd2) && (best == SCORE_W'(TARGET));

endmodule

// File: rtl/blackjack_table.sv
// Multi-player blackjack round controller: player turns, automatic dealer,
// and per-player WIN/TIE/LOSE outcomes held until the next round starts.
module blackjack_table
  import blackjack_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 5,
  parameter int TARGET       = 21,
  parameter int DEALER_STAND = 17,
  localparam int PIDX_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START_I,
  input  logic                   HIT_I,
  input  logic                   STAY_I,
  input  logic                   CARD_VALID_I,
  input  logic [3:0]             CARD_I,
  output logic [PIDX_W-1:0]      ACTIVE_PLAYER_O,
  output logic                   DEALER_REQ_O,
  output logic                   DONE_O,
  output logic [NUM_PLAYERS-1:0] WIN_O,
  output logic [NUM_PLAYERS-1:0] TIE_O,
  output logic [NUM_PLAYERS-1:0] LOSE_O
);

  localparam int DLR = NUM_PLAYERS;

  state_t                 state_reg;
  logic [PIDX_W-1:0]      p_reg;
  logic                   dealer_req_reg;
  logic                   done_reg;
  logic [NUM_PLAYERS-1:0] win_reg, tie_reg, lose_reg;
  logic [NUM_PLAYERS-1:0] win_next, tie_next, lose_next;

  logic [SCORE_W-1:0] hand_hard [NUM_PLAYERS+1];
  logic [SCORE_W-1:0] hand_best [NUM_PLAYERS+1];
  logic               hand_bust [NUM_PLAYERS+1];
  logic               hand_nat  [NUM_PLAYERS+1];
  logic [NUM_PLAYERS:0] hand_add;

  logic start_accept;
  logic turn_end;
  logic dealer_stands;

  assign start_accept  = START_I && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign turn_end      = STAY_I || (hand_hard[p_reg] > SCORE_W'(TARGET));
  assign dealer_stands = hand_best[DLR] >= SCORE_W'(DEALER_STAND);
  assign hand_add[DLR] = (state_reg == ST_DEALER) && dealer_req_reg && CARD_VALID_I;

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_PLAYERS; gi++) begin : g_hand
      blackjack_hand #(
        .SCORE_W (SCORE_W),
        .TARGET  (TARGET)
      ) u_hand (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (start_accept),
        .add     (hand_add[gi]),
        .card    (CARD_I),
        .hard    (hand_hard[gi]),
        .best    (hand_best[gi]),
        .bust    (hand_bust[gi]),
        .natural (hand_nat[gi])
      );
    end

    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [2:0] res;  // {win, tie, lose}

      assign hand_add[gi] = (state_reg == ST_PLAYER) && HIT_I && (p_reg == PIDX_W'(gi));

      always_comb begin
        res = 3'b000;
        if (hand_bust[gi])                       res = 3'b001;
        else if (hand_bust[DLR])                 res = 3'b100;
        else if (hand_nat[gi] != hand_nat[DLR])  res = hand_nat[gi] ? 3'b100 : 3'b001;
        else if (hand_best[gi] > hand_best[DLR]) res = 3'b100;
        else if (hand_best[gi] == hand_best[DLR]) res = 3'b010;
        else                                     res = 3'b001;
      end

      assign win_next[gi]  = res[2];
      assign tie_next[gi]  = res[1];
      assign lose_next[gi] = res[0];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      p_reg          <= '0;
      dealer_req_reg <= 1'b0;
      done_reg       <= 1'b0;
      win_reg        <= '0;
      tie_reg        <= '0;
      lose_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (START_I) begin
            state_reg <= ST_PLAYER;
            p_reg     <= '0;
            done_reg  <= 1'b0;
            win_reg   <= '0;
            tie_reg   <= '0;
            lose_reg  <= '0;
          end
        end
        ST_PLAYER: begin
          if (turn_end) begin
            if (p_reg == PIDX_W'(NUM_PLAYERS-1)) begin
              state_reg      <= ST_DEALER;
              dealer_req_reg <= !dealer_stands;
            end else begin
              p_reg <= p_reg + 1'b1;
            end
          end
        end
        // The request follows the hand a cycle late, but the exit looks at the hand directly.
        ST_DEALER: begin
          dealer_req_reg <= !dealer_stands;
          if (dealer_stands) state_reg <= ST_RESULT;
        end
        ST_RESULT: begin
          win_reg   <= win_next;
          tie_reg   <= tie_next;
          lose_reg  <= lose_next;
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ACTIVE_PLAYER_O = p_reg;
  assign DEALER_REQ_O    = dealer_req_reg;
  assign DONE_O          = done_reg;
  assign WIN_O           = win_reg;
  assign TIE_O           = tie_reg;
  assign LOSE_O          = lose_reg;

endmodule
